reg_wb_scoreboard: RTL and testbench
====================================

REG_WB_SCOREBOARD -- requirements
Module: reg_wb_scoreboard

Interface
REQ-001 Parameter LL_FIFO_DEPTH, default 2, sets the long-latency result buffer entry count (legal: 2 or 4).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_reg_wr_en_i / ex_reg_wr_adder_i / ex_reg_wr_data_i  input  1/`REG_ADDR_WIDTH/`CPU_WIDTH  single-cycle ALU result.
REQ-005 ll_issue_en_i / ll_issue_adder_i  input  1/`REG_ADDR_WIDTH  long-latency op (div/load) issued, destination register.
REQ-006 ll_valid_i / ll_adder_i / ll_data_i  input  1/`REG_ADDR_WIDTH/`CPU_WIDTH  long-latency result offer.
REQ-007 ll_ready_o  output  1  buffer can accept a result.
REQ-008 reg1_rd_adder_i / reg2_rd_adder_i / id_rd_adder_i  input  `REG_ADDR_WIDTH each  decode-stage source and destination addresses.
REQ-009 hazard_stall_o  output  1  decode must hold.
REQ-010 wb_reg_wr_en_o / wb_reg_wr_adder_o / wb_reg_wr_data_o  output  1/`REG_ADDR_WIDTH/`CPU_WIDTH  registered regfile write port; also feeds the forwarding unit's wb_* inputs.

Function
REQ-011 Busy bitmap, one bit per register; bit 0 SHALL remain 0 at all times.
REQ-012 ll_issue_en_i with nonzero address SHALL set busy[ll_issue_adder_i] at the next edge.
REQ-013 busy[a] SHALL clear at the edge that loads a long-latency write to a into the wb_* registers.
REQ-014 Set and clear of the same bit in one cycle: set wins.
REQ-015 A long-latency result transfers when ll_valid_i and ll_ready_o are both high at a clock edge.
REQ-016 ll_ready_o SHALL be high when the FIFO count < LL_FIFO_DEPTH, and SHALL be combinational from count only.
REQ-017 Write-port priority each cycle: (1) ex_reg_wr_en_i with nonzero address; (2) FIFO head; (3) bypass of the current ll transfer when the FIFO is empty; (4) idle.
REQ-018 A winning source SHALL appear on the wb_* outputs exactly 1 cycle later, with wb_reg_wr_en_o high for one cycle per write.
REQ-019 When an ALU write wins, a concurrent ll transfer SHALL push into the FIFO.
REQ-020 When the FIFO head wins, a concurrent transfer SHALL push in the same cycle; count is unchanged.
REQ-021 A transfer with ll_adder_i == 0 SHALL be accepted and discarded, with no write and no FIFO entry.
REQ-022 ALU writes to address 0 SHALL be dropped.
REQ-023 FIFO order SHALL be strict FIFO; pointers wrap modulo LL_FIFO_DEPTH.
REQ-024 hazard_stall_o = (reg1 nonzero and busy) OR (reg2 nonzero and busy) OR (id_rd nonzero and busy), purely combinational.
REQ-025 The stall SHALL drop in the cycle after the clearing write, when the forwarding unit supplies the value from wb_*.
REQ-026 wb_reg_wr_adder_o and wb_reg_wr_data_o SHALL hold their last values when wb_reg_wr_en_o is low.

Reset
REQ-027 While rst_n is low, and immediately on its assertion: busy = 0; FIFO count and pointers = 0; all wb_* outputs = 0; ll_ready_o = 1; hazard_stall_o = 0 for any inputs.
REQ-028 Reset mid-operation SHALL discard buffered results and pending busy bits without producing a write.
REQ-029 No transfer or issue SHALL be recorded in the first edge after rst_n rises unless it is sampled valid at that edge.

Verification
REQ-030 Issue x5; result x5 = 0xDEADBEEF two cycles later with no ALU write -> wb en=1, addr=5, data=0xDEADBEEF one cycle after transfer; stall (reg1=5) high until that edge, then low.
REQ-031 ALU write x3 = 0x11 in the same cycle as ll result x7 = 0x22 -> wb x3 = 0x11 in cycle n+1, wb x7 = 0x22 in cycle n+2; busy[7] clears at n+2.
REQ-032 ALU writes every cycle with 3 ll results offered (depth 2) -> ll_ready_o low after 2 accepted; after the ALU stops, writes drain in order.
REQ-033 Issue x0 plus ll result to x0 -> no busy set, no wb write, stall stays 0 with reg1 = 0.
REQ-034 Issue x9 in the same cycle as the clearing write of x9 -> busy[9] remains 1 and the stall persists.
REQ-035 Assert rst_n low with 2 buffered entries -> wb_reg_wr_en_o = 0 immediately, ll_ready_o = 1, and no writes after release.

Source files
------------

// File: rtl/reg_wb_scoreboard_if.sv
// Bundle of signals between the pipeline and the writeback scoreboard:
// ALU result, long-latency issue/result handshake, decode sources, and the
// registered register-file write port.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface reg_wb_scoreboard_if;
  logic                       ex_reg_wr_en_i;
  logic [`REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i;
  logic [`CPU_WIDTH-1:0]      ex_reg_wr_data_i;

  logic                       ll_issue_en_i;
  logic [`REG_ADDR_WIDTH-1:0] ll_issue_adder_i;

  logic                       ll_valid_i;
  logic [`REG_ADDR_WIDTH-1:0] ll_adder_i;
  logic [`CPU_WIDTH-1:0]      ll_data_i;
  logic                       ll_ready_o;

  logic [`REG_ADDR_WIDTH-1:0] reg1_rd_adder_i;
  logic [`REG_ADDR_WIDTH-1:0] reg2_rd_adder_i;
  logic [`REG_ADDR_WIDTH-1:0] id_rd_adder_i;
  logic                       hazard_stall_o;

  logic                       wb_reg_wr_en_o;
  logic [`REG_ADDR_WIDTH-1:0] wb_reg_wr_adder_o;
  logic [`CPU_WIDTH-1:0]      wb_reg_wr_data_o;

  modport slave (
    input  ex_reg_wr_en_i, ex_reg_wr_adder_i, ex_reg_wr_data_i,
    input  ll_issue_en_i, ll_issue_adder_i,
    input  ll_valid_i, ll_adder_i, ll_data_i,
    output ll_ready_o,
    input  reg1_rd_adder_i, reg2_rd_adder_i, id_rd_adder_i,
    output hazard_stall_o,
    output wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o
  );

  modport master (
    output ex_reg_wr_en_i, ex_reg_wr_adder_i, ex_reg_wr_data_i,
    output ll_issue_en_i, ll_issue_adder_i,
    output ll_valid_i, ll_adder_i, ll_data_i,
    input  ll_ready_o,
    output reg1_rd_adder_i, reg2_rd_adder_i, id_rd_adder_i,
    input  hazard_stall_o,
    input  wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o
  );
endinterface

// File: rtl/reg_wb_scoreboard.sv
// Writeback arbiter and register scoreboard. Single-cycle ALU results always
// win the register-file write port; long-latency results (div/load) are
// buffered in a small FIFO or bypassed straight through when the port is
// free. A busy bitmap tracks registers with an outstanding long-latency
// write and stalls decode until that write reaches the wb_* registers.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module reg_wb_scoreboard #(
  parameter int LL_FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  reg_wb_scoreboard_if.slave bus
);
  localparam int AW   = `REG_ADDR_WIDTH;
  localparam int DW   = `CPU_WIDTH;
  localparam int NREG = 1 << AW;
  localparam int PW   = $clog2(LL_FIFO_DEPTH);
  localparam int CW   = $clog2(LL_FIFO_DEPTH + 1);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  logic [AW-1:0] fifo_addr [LL_FIFO_DEPTH];
  logic [DW-1:0] fifo_data [LL_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  logic ll_ready;
  logic ll_xfer;
  logic ll_keep;
  logic alu_win;
  logic fifo_win;
  logic bypass_win;
  logic push;
  logic pop;

  // Ready depends on occupancy only, so upstream never sees a comb loop.
  assign ll_ready   = (count < CW'(LL_FIFO_DEPTH));
  assign ll_xfer    = bus.ll_valid_i && ll_ready;
  // Results aimed at x0 are accepted and dropped on the floor.
  assign ll_keep    = ll_xfer && (bus.ll_adder_i != '0);
  assign alu_win    = bus.ex_reg_wr_en_i && (bus.ex_reg_wr_adder_i != '0);
  assign fifo_win   = !alu_win && (count != '0);
  assign bypass_win = !alu_win && (count == '0) && ll_keep;
  assign push       = ll_keep && !bypass_win;
  assign pop        = fifo_win;

  // Busy set/clear masks; OR-ing the set mask after the clear makes set win.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.ll_issue_en_i && (bus.ll_issue_adder_i != '0))
      set_mask[bus.ll_issue_adder_i] = 1'b1;
    if (fifo_win)
      clr_mask[fifo_addr[rd_ptr]] = 1'b1;
    else if (bypass_win)
      clr_mask[bus.ll_adder_i] = 1'b1;
  end

  // Busy bitmap; x0 is never tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ll_adder_i;
      fifo_data[wr_ptr] <= bus.ll_data_i;
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Registered write port: ALU, then FIFO head, then bypass; address and
  // data hold their last values on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (alu_win) begin
      wb_en   <= 1'b1;
      wb_addr <= bus.ex_reg_wr_adder_i;
      wb_data <= bus.ex_reg_wr_data_i;
    end else if (fifo_win) begin
      wb_en   <= 1'b1;
      wb_addr <= fifo_addr[rd_ptr];
      wb_data <= fifo_data[rd_ptr];
    end else if (bypass_win) begin
      wb_en   <= 1'b1;
      wb_addr <= bus.ll_adder_i;
      wb_data <= bus.ll_data_i;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  assign bus.ll_ready_o        = ll_ready;
  assign bus.wb_reg_wr_en_o    = wb_en;
  assign bus.wb_reg_wr_adder_o = wb_addr;
  assign bus.wb_reg_wr_data_o  = wb_data;

  // Once busy clears, the forwarding path supplies the value from wb_*.
  assign bus.hazard_stall_o =
      ((bus.reg1_rd_adder_i != '0) && busy[bus.reg1_rd_adder_i]) ||
      ((bus.reg2_rd_adder_i != '0) && busy[bus.reg2_rd_adder_i]) ||
      ((bus.id_rd_adder_i   != '0) && busy[bus.id_rd_adder_i]);

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed bench for reg_wb_scoreboard (depth 2). Expected writes go into a
// queue as stimulus is driven; a monitor pops and compares every wb write.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_reg_wb_scoreboard;
  localparam int AW = `REG_ADDR_WIDTH;
  localparam int DW = `CPU_WIDTH;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  wr_t  sb[$];
  wr_t  exp_wr;

  reg_wb_scoreboard_if bus();

  reg_wb_scoreboard #(.LL_FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_reg_wr_en_i    = 1'b0;
    bus.ex_reg_wr_adder_i = '0;
    bus.ex_reg_wr_data_i  = '0;
    bus.ll_issue_en_i     = 1'b0;
    bus.ll_issue_adder_i  = '0;
    bus.ll_valid_i        = 1'b0;
    bus.ll_adder_i        = '0;
    bus.ll_data_i         = '0;
  endtask

  task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ex_reg_wr_en_i    = 1'b1;
    bus.ex_reg_wr_adder_i = a;
    bus.ex_reg_wr_data_i  = d;
  endtask

  task automatic ll(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ll_valid_i = 1'b1;
    bus.ll_adder_i = a;
    bus.ll_data_i  = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.ll_issue_en_i    = 1'b1;
    bus.ll_issue_adder_i = a;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back('{a: a, d: d});
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(posedge clk) begin
    #2;
    if (bus.wb_reg_wr_en_o === 1'b1) begin
      chk("wb_expected_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_wr = sb.pop_front();
        chk("wb_order", {bus.wb_reg_wr_adder_o, bus.wb_reg_wr_data_o}, {exp_wr.a, exp_wr.d});
      end
    end
  end

  initial begin
    idle();
    bus.reg1_rd_adder_i = '0;
    bus.reg2_rd_adder_i = '0;
    bus.id_rd_adder_i   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    // Busy inputs during reset must not leak through.
    issue(5); ll(6, 32'h1234);
    bus.reg1_rd_adder_i = 5;
    bus.reg2_rd_adder_i = 6;
    bus.id_rd_adder_i   = 7;
    #1;
    chk("rst_wb_en",    bus.wb_reg_wr_en_o,    0);
    chk("rst_wb_addr",  bus.wb_reg_wr_adder_o, 0);
    chk("rst_wb_data",  bus.wb_reg_wr_data_o,  0);
    chk("rst_ready",    bus.ll_ready_o,        1);
    chk("rst_stall",    bus.hazard_stall_o,    0);
    tick();
    chk("rst_edge_wb_en", bus.wb_reg_wr_en_o,  0);
    chk("rst_edge_stall", bus.hazard_stall_o,  0);
    idle();
    bus.reg2_rd_adder_i = '0;
    bus.id_rd_adder_i   = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_stall", bus.hazard_stall_o, 0);
    chk("post_rst_wb_en", bus.wb_reg_wr_en_o, 0);

    // Issue x5, result two cycles later, bypassed through an empty FIFO.
    issue(5);
    tick();
    idle();
    #1;
    chk("t030_stall_set", bus.hazard_stall_o, 1);
    tick();
    chk("t030_stall_hold", bus.hazard_stall_o, 1);
    ll(5, 32'hDEADBEEF);
    expect_wr(5, 32'hDEADBEEF);
    #1;
    chk("t030_ready", bus.ll_ready_o, 1);
    tick();
    idle();
    chk("t030_wb_en",   bus.wb_reg_wr_en_o,    1);
    chk("t030_wb_addr", bus.wb_reg_wr_adder_o, 5);
    chk("t030_wb_data", bus.wb_reg_wr_data_o,  32'hDEADBEEF);
    chk("t030_stall_clear", bus.hazard_stall_o, 0);
    tick();
    chk("t030_wb_en_low",  bus.wb_reg_wr_en_o,    0);
    chk("t030_addr_hold",  bus.wb_reg_wr_adder_o, 5);
    chk("t030_data_hold",  bus.wb_reg_wr_data_o,  32'hDEADBEEF);

    // ALU x3 and ll x7 in the same cycle: ALU first, ll the cycle after.
    issue(7);
    bus.reg1_rd_adder_i = 7;
    tick();
    idle();
    #1;
    chk("t031_stall_set", bus.hazard_stall_o, 1);
    alu(3, 32'h11);
    ll(7, 32'h22);
    expect_wr(3, 32'h11);
    expect_wr(7, 32'h22);
    tick();
    idle();
    chk("t031_n1_addr", bus.wb_reg_wr_adder_o, 3);
    chk("t031_n1_data", bus.wb_reg_wr_data_o,  32'h11);
    chk("t031_n1_stall", bus.hazard_stall_o,   1);
    tick();
    chk("t031_n2_en",   bus.wb_reg_wr_en_o,    1);
    chk("t031_n2_addr", bus.wb_reg_wr_adder_o, 7);
    chk("t031_n2_data", bus.wb_reg_wr_data_o,  32'h22);
    chk("t031_n2_stall", bus.hazard_stall_o,   0);
    tick();
    bus.reg1_rd_adder_i = '0;

    // ALU writes every cycle fill the FIFO; ll drains in order afterwards.
    expect_wr(20, 32'h100); expect_wr(21, 32'h101);
    expect_wr(22, 32'h102); expect_wr(23, 32'h103);
    expect_wr(10, 32'hA0);  expect_wr(11, 32'hA1);
    expect_wr(12, 32'hA2);
    alu(20, 32'h100); ll(10, 32'hA0);
    tick();
    alu(21, 32'h101); ll(11, 32'hA1);
    #1;
    chk("t032_ready_one", bus.ll_ready_o, 1);
    tick();
    alu(22, 32'h102); ll(12, 32'hA2);
    #1;
    chk("t032_ready_full_a", bus.ll_ready_o, 0);
    tick();
    alu(23, 32'h103);
    #1;
    chk("t032_ready_full_b", bus.ll_ready_o, 0);
    tick();
    bus.ex_reg_wr_en_i = 1'b0;
    tick();
    chk("t032_drain0_addr", bus.wb_reg_wr_adder_o, 10);
    chk("t032_ready_again", bus.ll_ready_o, 1);
    tick();
    idle();
    chk("t032_drain1_addr", bus.wb_reg_wr_adder_o, 11);
    tick();
    chk("t032_drain2_addr", bus.wb_reg_wr_adder_o, 12);
    tick();
    chk("t032_idle_en", bus.wb_reg_wr_en_o, 0);

    // x0 traffic: issue and result to x0, then ALU to x0, all dropped.
    issue(0); ll(0, 32'h55);
    tick();
    idle();
    chk("t033_wb_en",  bus.wb_reg_wr_en_o, 0);
    chk("t033_stall",  bus.hazard_stall_o, 0);
    chk("t033_ready",  bus.ll_ready_o,     1);
    alu(0, 32'h66);
    tick();
    idle();
    chk("t033_alu0_en", bus.wb_reg_wr_en_o, 0);
    tick();
    chk("t033_no_late_write", bus.wb_reg_wr_en_o, 0);

    // Re-issue x9 in the same cycle its previous write clears it.
    issue(9);
    bus.reg2_rd_adder_i = 9;
    tick();
    idle();
    #1;
    chk("t034_stall_set", bus.hazard_stall_o, 1);
    issue(9); ll(9, 32'h99);
    expect_wr(9, 32'h99);
    tick();
    idle();
    chk("t034_wb_addr", bus.wb_reg_wr_adder_o, 9);
    chk("t034_stall_persist", bus.hazard_stall_o, 1);
    bus.reg2_rd_adder_i = '0;
    bus.id_rd_adder_i   = 9;
    #1;
    chk("t034_stall_id_rd", bus.hazard_stall_o, 1);
    ll(9, 32'h999);
    expect_wr(9, 32'h999);
    tick();
    idle();
    chk("t034_stall_final", bus.hazard_stall_o, 0);
    bus.id_rd_adder_i = '0;
    tick();

    // Reset with two buffered results and a pending busy bit.
    issue(13);
    tick();
    idle();
    alu(1, 32'h1); ll(13, 32'hC13);
    expect_wr(1, 32'h1);
    tick();
    alu(2, 32'h2); ll(14, 32'hC14);
    expect_wr(2, 32'h2);
    tick();
    idle();
    bus.reg1_rd_adder_i = 13;
    #1;
    chk("t035_buffered_full", bus.ll_ready_o, 0);
    chk("t035_busy_pending", bus.hazard_stall_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t035_rst_wb_en", bus.wb_reg_wr_en_o, 0);
    chk("t035_rst_ready", bus.ll_ready_o,     1);
    chk("t035_rst_stall", bus.hazard_stall_o, 0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t035_post_en_a", bus.wb_reg_wr_en_o, 0);
    tick();
    chk("t035_post_en_b", bus.wb_reg_wr_en_o, 0);
    tick();
    chk("t035_post_stall", bus.hazard_stall_o, 0);
    chk("t035_post_ready", bus.ll_ready_o, 1);
    #5;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
